// File: rtl/output_stream_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_store_pkg
// Description : Shared types and constants for the output stream store sink.
// Revision    : 1.0 - initial release
// ============================================================================
package output_stream_store_pkg;

    localparam int COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } store_state_t;

endpackage
`default_nettype wire

// File: rtl/output_stream_store_if.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_store_if
// Description : Elastic input stream plus req/gnt memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_stream_store_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_v;
    logic                  din_r;
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;

    // master: the environment (stream producer and memory arbiter); slave: the store
    modport master (
        output din, din_v, mem_gnt,
        input  din_r, mem_req, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  din, din_v, mem_gnt,
        output din_r, mem_req, mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/output_stream_store_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_store_sync_fifo
// Description : Registered FIFO, no read-during-write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module output_stream_store_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]        wr_ptr_q;
    logic [PTR_W:0]        rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_stream_store.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_store
// Description : Stores a configured number of stream words at base + i*stride.
// Revision    : 1.0 - initial release
// ============================================================================
module output_stream_store
    import output_stream_store_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH-1:0]  stride,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output_stream_store_if.slave   bus
);
    store_state_t           state_q;
    store_state_t           state_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] acc_q;
    logic [COUNT_WIDTH-1:0] grn_q;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [ADDR_WIDTH-1:0]  addr_q;

    logic                   run;
    logic                   launch;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_head;
    logic                   push;
    logic                   fire;
    logic                   last_grant;

    assign run        = (state_q == ST_RUN);
    assign launch     = (state_q == ST_IDLE) & start;
    assign push       = bus.din_v & bus.din_r;
    assign fire       = bus.mem_req & bus.mem_gnt;
    assign last_grant = fire & ((grn_q + COUNT_WIDTH'(1)) == cnt_q);

    // Acceptance stops at count so surplus words stall upstream
    assign bus.din_r     = run & ~fifo_full & (acc_q < cnt_q);
    assign bus.mem_req   = run & ~fifo_empty;
    assign bus.mem_we    = bus.mem_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = bus.mem_req ? fifo_head : '0;

    output_stream_store_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (bus.din),
        .pop_i   (fire),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_grant) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Address accumulator wraps naturally at the address width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            grn_q    <= '0;
            stride_q <= '0;
            addr_q   <= '0;
        end else if (launch) begin
            cnt_q    <= count;
            acc_q    <= '0;
            grn_q    <= '0;
            stride_q <= stride;
            addr_q   <= base_addr;
        end else begin
            if (push) begin
                acc_q <= acc_q + COUNT_WIDTH'(1);
            end
            if (fire) begin
                grn_q  <= grn_q + COUNT_WIDTH'(1);
                addr_q <= addr_q + stride_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_stream_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_stream_store
// Description : Self-checking bench with a transaction-level store model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_stream_store;
    localparam int DW = 32;
    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] stride = '0;
    logic [15:0] count = '0;
    logic        busy;
    logic        done;

    output_stream_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    output_stream_store #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] src_q [$];
    logic [31:0] pend_q [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    bit          mon_en = 1'b0;
    int          vld_pct = 100;
    int          gnt_mode = 1;
    bit          m_busy = 1'b0;
    bit          busy_exp = 1'b0;
    bit          done_exp = 1'b0;
    int          m_cnt = 0;
    int          m_acc = 0;
    int          m_grn = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_stride = '0;
    int          done_seen = 0;
    int          req_seen = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    logic [31:0] data_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: write i of a transfer goes to base + i*stride carrying the i-th accepted word
    always @(negedge clk) begin : mon
        bit          cur_idle;
        bit          nd_done;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        if (mon_en) begin
            check("done", 32'(done), 32'(done_exp));
            check("busy", 32'(busy), 32'(busy_exp));
            check("mem_we", 32'(bus.mem_we), 32'(bus.mem_req));
            if (done) done_seen++;
            if (bus.mem_req) req_seen++;
            if (stall_prev) begin
                check("hold_req", 32'(bus.mem_req), 32'd1);
                check("hold_addr", bus.mem_addr, addr_prev);
                check("hold_wdata", bus.mem_wdata, data_prev);
            end
            cur_idle = !busy_exp && !done_exp;
            nd_done  = 1'b0;

            if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
                bus.din_v = 1'b1;
                bus.din   = src_q[0];
            end else begin
                bus.din_v = 1'b0;
                bus.din   = $urandom;
            end
            case (gnt_mode)
                0:       bus.mem_gnt = 1'b0;
                1:       bus.mem_gnt = 1'b1;
                default: bus.mem_gnt = ($urandom_range(99) < 65);
            endcase

            if (bus.mem_req && bus.mem_gnt) begin
                check("write_pending", 32'(pend_q.size() > 0 && m_busy), 32'd1);
                exp_a = m_base + 32'(m_grn) * m_stride;
                exp_d = (pend_q.size() > 0) ? pend_q.pop_front() : 'x;
                check("mem_addr", bus.mem_addr, exp_a);
                check("mem_wdata", bus.mem_wdata, exp_d);
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_wdata);
                m_grn++;
                if (m_grn == m_cnt) begin
                    m_busy  = 1'b0;
                    nd_done = 1'b1;
                end
            end

            if (bus.din_r) begin
                check("din_r_allowed", 32'(m_busy && m_acc < m_cnt), 32'd1);
                if (bus.din_v) begin
                    pend_q.push_back(src_q.pop_front());
                    m_acc++;
                end
            end

            if (start && cur_idle) begin
                if (count == 16'd0) begin
                    nd_done = 1'b1;
                end else begin
                    m_busy   = 1'b1;
                    m_cnt    = int'(count);
                    m_acc    = 0;
                    m_grn    = 0;
                    m_base   = base_addr;
                    m_stride = stride;
                    pend_q.delete();
                end
            end

            stall_prev = bus.mem_req && !bus.mem_gnt;
            addr_prev  = bus.mem_addr;
            data_prev  = bus.mem_wdata;
            done_exp   = nd_done;
            busy_exp   = m_busy;
        end else begin
            bus.din_v   = 1'b0;
            bus.din     = '0;
            bus.mem_gnt = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
        @(posedge clk); #1;
        log_addr.delete();
        log_data.delete();
        base_addr = b;
        stride    = s;
        count     = c;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!m_busy && !busy_exp && !done_exp) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_din_r"}, 32'(bus.din_r), 32'd0);
        check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        int d0;
        int r0;
        int n;
        int extra;
        bit ok;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Basic three-word transfer, back-to-back stream, grant tied high
        d0 = done_seen;
        vld_pct = 100; gnt_mode = 1;
        src_q = '{32'hA, 32'hB, 32'hC};
        do_start(32'h100, 32'd4, 16'd3);
        wait_idle(50);
        check("t1_nwrites", 32'(log_addr.size()), 32'd3);
        if (log_addr.size() == 3) begin
            check("t1_a0", log_addr[0], 32'h100); check("t1_d0", log_data[0], 32'hA);
            check("t1_a1", log_addr[1], 32'h104); check("t1_d1", log_data[1], 32'hB);
            check("t1_a2", log_addr[2], 32'h108); check("t1_d2", log_data[2], 32'hC);
        end
        check("t1_done_pulses", 32'(done_seen - d0), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Surplus words are never accepted
        src_q = '{$urandom, $urandom, $urandom, $urandom};
        do_start(32'h2000, 32'd16, 16'd2);
        wait_idle(50);
        repeat (4) @(posedge clk);
        #1;
        check("t2_leftover", 32'(src_q.size()), 32'd2);
        check("t2_din_r", 32'(bus.din_r), 32'd0);
        src_q.delete();

        // Grant withheld mid-transfer: FIFO fills, outputs hold, order kept
        for (int i = 0; i < 8; i++) src_q.push_back($urandom);
        do_start(32'h4000, 32'd4, 16'd8);
        repeat (2) @(posedge clk);
        #1;
        gnt_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        check("t3_fifo_fill", 32'(pend_q.size()), 32'd4);
        check("t3_din_r_full", 32'(bus.din_r), 32'd0);
        check("t3_req_held", 32'(bus.mem_req), 32'd1);
        gnt_mode = 1;
        wait_idle(80);
        check("t3_nwrites", 32'(log_addr.size()), 32'd8);

        // Zero-length launch: done next cycle, no memory traffic
        d0 = done_seen; r0 = req_seen;
        do_start(32'h8000, 32'd4, 16'd0);
        wait_idle(10);
        check("t4_done_pulses", 32'(done_seen - d0), 32'd1);
        check("t4_no_req", 32'(req_seen - r0), 32'd0);

        // Address wrap at the top of the address space
        src_q = '{$urandom, $urandom};
        do_start(32'hFFFF_FFFC, 32'd8, 16'd2);
        wait_idle(50);
        check("t5_nwrites", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("t5_a0", log_addr[0], 32'hFFFF_FFFC);
            check("t5_a1", log_addr[1], 32'h0000_0004);
        end

        // Asynchronous reset with two words queued
        gnt_mode = 0;
        for (int i = 0; i < 5; i++) src_q.push_back($urandom);
        do_start(32'h300, 32'd4, 16'd6);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (pend_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_queue_timeout", 32'(ok), 32'd1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("t6_rst");
        src_q.delete(); pend_q.delete();
        m_busy = 1'b0; busy_exp = 1'b0; done_exp = 1'b0; stall_prev = 1'b0;
        m_cnt = 0; m_acc = 0; m_grn = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mon_en   = 1'b1;
        gnt_mode = 1;
        src_q = '{32'h11, 32'h22, 32'h33};
        do_start(32'h500, 32'd4, 16'd3);
        wait_idle(50);
        check("t6_after_nwrites", 32'(log_addr.size()), 32'd3);

        // Randomized transfers under random valid and grant patterns
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 12);
            extra = $urandom_range(0, 3);
            vld_pct = $urandom_range(40, 100);
            gnt_mode = 2;
            for (int i = 0; i < n + extra; i++) src_q.push_back($urandom);
            d0 = done_seen;
            do_start($urandom, (t % 2 == 0) ? 32'($urandom_range(0, 64)) : $urandom, 16'(n));
            wait_idle(600);
            check("rnd_nwrites", 32'(log_addr.size()), 32'(n));
            check("rnd_leftover", 32'(src_q.size()), 32'(extra));
            check("rnd_done_pulses", 32'(done_seen - d0), 32'd1);
            src_q.delete();
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
